seek_sequencer: RTL

- Head-positioning sequencer in front of the disc step controller.
- Tracks the absolute head position (current track register).
- Converts host SEEK/RECALIBRATE commands into extension/command register writes on the step controller, then waits for stepping to finish and a head-settle delay.
- Reports BUSY/DONE/ERROR to the host register block.

---
 rtl/seek_sequencer_if.sv | 41 ++++
 rtl/seek_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seek_sequencer_if.sv
// Host command / status and step-controller register bus of the seek sequencer.
// slave = sequencer side, master = host plus step controller (or a testbench).
// Optional DOUBLE_STEP input exists only when SEEK_SEQ_DOUBLE_STEP_EN is defined.
interface seek_sequencer_if #(
  parameter int TRACK_W = 8
) ();
  logic               cmd_seek;
  logic               cmd_recal;
  logic [TRACK_W-1:0] target;
`ifdef SEEK_SEQ_DOUBLE_STEP_EN
  logic               double_step;
`endif
  logic               busy;
  logic               done;
  logic [1:0]         err_code;
  logic [TRACK_W-1:0] cur_track;
  logic               track_valid;
  logic [7:0]         sc_ctlbyte;
  logic               sc_write_ext;
  logic               sc_write_cmd;
  logic               sc_is_stepping;
  logic               sc_track0_hit;

  modport slave (
`ifdef SEEK_SEQ_DOUBLE_STEP_EN
    input  double_step,
`endif
    input  cmd_seek, cmd_recal, target, sc_is_stepping, sc_track0_hit,
    output busy, done, err_code, cur_track, track_valid,
    output sc_ctlbyte, sc_write_ext, sc_write_cmd
  );

  modport master (
`ifdef SEEK_SEQ_DOUBLE_STEP_EN
    output double_step,
`endif
    output cmd_seek, cmd_recal, target, sc_is_stepping, sc_track0_hit,
    input  busy, done, err_code, cur_track, track_valid,
    input  sc_ctlbyte, sc_write_ext, sc_write_cmd
  );
endinterface

// File: rtl/seek_sequencer.sv
// Head-positioning sequencer: turns SEEK/RECAL into step-controller register writes,
// waits for stepping plus head settle, tracks the absolute head position.
// Optional macro SEEK_SEQ_DOUBLE_STEP_EN adds double_step (2 physical steps per track).
module seek_sequencer #(
  parameter int                  TRACK_W       = 8,
  parameter int                  SETTLE_W      = 16,
  parameter logic [SETTLE_W-1:0] SETTLE_CYCLES = 16'd15000
) (
  input logic            clk,
  input logic            rst,
  seek_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CALC, LOAD_EXT, LOAD_CMD, WAIT_START, WAIT_DONE, SETTLE, FINISH
  } state_t;

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_CYCLES - 1'b1;

  state_t              state, next_state;
  logic [TRACK_W-1:0]  tgt;
  logic                is_recal;
  logic                dir;
  logic [14:0]         count;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [TRACK_W-1:0]  cur_track;
  logic                track_valid;
  logic [1:0]          err_code;
`ifdef SEEK_SEQ_DOUBLE_STEP_EN
  logic                dbl;
`endif

  logic                calc_dir;
  logic [TRACK_W-1:0]  diff;
  logic [14:0]         calc_steps;
  logic [14:0]         calc_count;
  logic [7:0]          ctlbyte;
  logic                write_ext;
  logic                write_cmd;

  // Direction and programmed count (steps-1) from the latched command and current track
  always_comb begin
    calc_dir   = 1'b1;
    diff       = '0;
    calc_steps = '0;
    calc_count = 15'h7FFF;
    if (!is_recal) begin
      if (tgt > cur_track) begin
        calc_dir = 1'b0;
        diff     = tgt - cur_track;
      end else begin
        calc_dir = 1'b1;
        diff     = cur_track - tgt;
      end
`ifdef SEEK_SEQ_DOUBLE_STEP_EN
      calc_steps = dbl ? 15'({diff, 1'b0}) : 15'(diff);
`else
      calc_steps = 15'(diff);
`endif
      calc_count = calc_steps - 15'd1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and register-bus strobes; ctlbyte is zero whenever no strobe is up
  always_comb begin
    next_state = state;
    ctlbyte    = 8'h00;
    write_ext  = 1'b0;
    write_cmd  = 1'b0;
    case (state)
      IDLE:       if (bus.cmd_seek || bus.cmd_recal) next_state = CALC;
      CALC: begin
        if (is_recal)                next_state = LOAD_EXT;
        else if (!track_valid)       next_state = FINISH;
        else if (tgt == cur_track)   next_state = FINISH;
        else                         next_state = LOAD_EXT;
      end
      LOAD_EXT: begin
        write_ext  = 1'b1;
        ctlbyte    = count[14:7];
        next_state = LOAD_CMD;
      end
      LOAD_CMD: begin
        write_cmd  = 1'b1;
        ctlbyte    = {dir, count[6:0]};
        next_state = WAIT_START;
      end
      WAIT_START: next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (!bus.sc_is_stepping)
          next_state = (SETTLE_CYCLES == '0) ? FINISH : SETTLE;
      end
      SETTLE:     if (settle_cnt == SETTLE_LAST) next_state = FINISH;
      FINISH:     next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Command latch, step parameters, position and error bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt         <= '0;
      is_recal    <= 1'b0;
      dir         <= 1'b0;
      count       <= '0;
      cur_track   <= '0;
      track_valid <= 1'b0;
      err_code    <= 2'b00;
`ifdef SEEK_SEQ_DOUBLE_STEP_EN
      dbl         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.cmd_seek || bus.cmd_recal) begin
          is_recal <= bus.cmd_recal;
          tgt      <= bus.target;
          err_code <= 2'b00;
`ifdef SEEK_SEQ_DOUBLE_STEP_EN
          dbl      <= bus.double_step;
`endif
        end
        CALC: begin
          dir   <= calc_dir;
          count <= calc_count;
          if (!is_recal && !track_valid) err_code <= 2'b01;
        end
        WAIT_DONE: if (!bus.sc_is_stepping) begin
          if (is_recal) begin
            if (bus.sc_track0_hit) begin
              cur_track   <= '0;
              track_valid <= 1'b1;
              err_code    <= 2'b00;
            end else begin
              track_valid <= 1'b0;
              err_code    <= 2'b10;
            end
          end else if (dir && bus.sc_track0_hit && (tgt != '0)) begin
            // Reached the stop before the target: the head is really at track 0
            cur_track <= '0;
            err_code  <= 2'b11;
          end else begin
            cur_track <= tgt;
            err_code  <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

  // Head-settle counter, runs only while in SETTLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 settle_cnt <= '0;
    else if (state == SETTLE) settle_cnt <= settle_cnt + 1'b1;
    else                     settle_cnt <= '0;
  end

  assign bus.busy         = (state != IDLE) && (state != FINISH);
  assign bus.done         = (state == FINISH);
  assign bus.err_code     = err_code;
  assign bus.cur_track    = cur_track;
  assign bus.track_valid  = track_valid;
  assign bus.sc_ctlbyte   = ctlbyte;
  assign bus.sc_write_ext = write_ext;
  assign bus.sc_write_cmd = write_cmd;

endmodule
